// File: rtl/mmio_pkg.sv
// Shared register map and CTRL bit positions for the MMIO/UART bridge.
package mmio_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CNTRST = 8'h18;

  localparam int CTRL_TX_NOT_FULL  = 0;
  localparam int CTRL_RX_NOT_EMPTY = 1;
  localparam int CTRL_TX_OVF       = 2;
  localparam int CTRL_RX_OVF       = 3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A push while full is still
// accepted when a pop happens in the same cycle (the slot frees up).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Status flags, qualified push/pop and next pointers.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; reset discards all buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents only matter between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_bridge.sv
// MMIO responder for the 0x8xxx_xxxx window: UART TX/RX FIFOs, sticky
// overflow flags, cycle/instruction counters, 1-cycle registered read data.
module mmio_uart_bridge
  import mmio_pkg::*;
#(
  parameter int         TX_DEPTH    = 8,
  parameter int         RX_DEPTH    = 8,
  parameter logic [3:0] MMIO_NIBBLE = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic [31:0] rsp_rdata,
  input  logic        inst_retire,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  logic [7:0]  off;
  logic        rd_hit, wr_hit;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic        ctrl_clr, cnt_rst, tx_ovf_set, rx_ovf_set;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        unused_bits;

  assign unused_bits = ^{req_addr[27:8], req_addr[1:0], req_wdata[31:8], req_wmask[3:1]};

  // Decode the request and derive FIFO controls and flag/counter updates.
  always_comb begin
    off        = {req_addr[7:2], 2'b00};
    rd_hit     = req_valid && (req_addr[31:28] == MMIO_NIBBLE) && !req_we;
    wr_hit     = req_valid && (req_addr[31:28] == MMIO_NIBBLE) && req_we;
    rx_pop     = rd_hit && (off == OFF_RX);
    tx_push    = wr_hit && (off == OFF_TX) && req_wmask[0];
    tx_pop     = !tx_empty && tx_ready;
    ctrl_clr   = wr_hit && (off == OFF_CTRL) && req_wmask[0];
    cnt_rst    = wr_hit && (off == OFF_CNTRST);
    tx_ovf_set = tx_push && tx_full && !tx_pop;
    // A full RX FIFO is never empty, so rx_pop here is a real pop.
    rx_ovf_set = rx_valid && rx_full && !rx_pop;
    tx_ovf_d   = (tx_ovf_q && !ctrl_clr) || tx_ovf_set;
    rx_ovf_d   = (rx_ovf_q && !ctrl_clr) || rx_ovf_set;
    cycle_cnt_d = cnt_rst ? 32'h0 : cycle_cnt_q + 32'h1;
    instr_cnt_d = cnt_rst ? 32'h0 : instr_cnt_q + {31'h0, inst_retire};
  end

  // Read mux, sampled from pre-update state in the request cycle.
  always_comb begin
    rsp_rdata_d = '0;
    if (rd_hit) begin
      case (off)
        OFF_CTRL: begin
          rsp_rdata_d[CTRL_TX_NOT_FULL]  = !tx_full;
          rsp_rdata_d[CTRL_RX_NOT_EMPTY] = !rx_empty;
          rsp_rdata_d[CTRL_TX_OVF]       = tx_ovf_q;
          rsp_rdata_d[CTRL_RX_OVF]       = rx_ovf_q;
        end
        OFF_RX:    if (!rx_empty) rsp_rdata_d = {24'h0, rx_head};
        OFF_CYCLE: rsp_rdata_d = cycle_cnt_q;
        OFF_INSTR: rsp_rdata_d = instr_cnt_q;
        default:   rsp_rdata_d = '0;
      endcase
    end
  end

  // Counters, sticky flags and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign tx_valid  = !tx_empty;
  assign tx_data   = tx_empty ? 8'h0 : tx_head;
  assign rx_ready  = 1'b1;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(req_wdata[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
Memory-mapped I/O responder for the CPU's 0x8xxx_xxxx load/store window. It decodes single-cycle load/store requests from the MEM stage and returns registered read data one cycle later, aligned with dmem/bios read latency. It buffers UART traffic in TX and RX FIFOs and keeps cycle and retired-instruction counters. It sits between the core's memory stage and the on-chip uart (byte ready/valid on both directions).

Parameters:
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
MMIO_NIBBLE, 4'h8, value of req_addr[31:28] that selects this block

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  load/store request this cycle (MEM stage)
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address; [1:0] ignored
req_wdata  in  32  store data, already lane-shifted
req_wmask  in  4  byte write enables
rsp_rdata  out  32  load data, valid the cycle after the request
inst_retire  in  1  one pulse per retired instruction
tx_data  out  8  byte to uart transmitter
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  uart transmitter accepts byte
rx_data  in  8  byte from uart receiver
rx_valid  in  1  receiver byte available
rx_ready  out  1  always 1; bridge always consumes

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. On reset both FIFOs are empty, both counters are 0, sticky flags are 0, rsp_rdata=0, tx_valid=0, tx_data=0, rx_ready=1.
- Decode: the block is hit when req_valid && req_addr[31:28]==MMIO_NIBBLE. Offset is req_addr[7:0].
- 0x00 CTRL. Read returns bit0=tx_not_full, bit1=rx_not_empty, bit2=tx_overflow, bit3=rx_overflow, others 0. Write with wmask[0] clears bits 2 and 3.
- 0x04 RX_DATA. Read returns {24'b0, RX head} and pops in the request cycle. If the FIFO is empty, it returns 0 with no pop.
- 0x08 TX_DATA. Write with wmask[0] pushes wdata[7:0]. If the FIFO is full and not popping that cycle, the byte is dropped and tx_overflow is set.
- 0x10 CYCLE. Read returns cycle_cnt sampled in the request cycle.
- 0x14 INSTR. Read returns instr_cnt sampled in the request cycle.
- 0x18 CNT_RST. Any write zeroes both counters.
- Unmapped offsets, wrong direction, or miss: reads return 0, writes are ignored, no side effects.
- rsp_rdata is a registered read mux, so latency is exactly 1 cycle. rsp_rdata is 0 the cycle after a non-hit or a store.
- cycle_cnt increments every cycle. instr_cnt increments when inst_retire=1. Both are 32-bit and wrap 0xFFFF_FFFF->0. A CNT_RST write in the same cycle as an increment leaves the counter at 0 next cycle.
- TX side: tx_valid=!tx_empty and tx_data=TX head, combinational from FIFO storage. Pop when tx_valid&&tx_ready. A CPU push into a full FIFO in the same cycle as a pop is accepted and the count is unchanged.
- RX side: push when rx_valid. A push into a full FIFO is dropped and sets rx_overflow, unless the CPU pops RX_DATA that same cycle, in which case it is accepted. Push and pop on an empty RX FIFO in the same cycle: the read returns 0 and the pushed byte is retained.
- FIFO ordering is strict FIFO. Pointers are log2(depth)+1 bits; full and empty are derived from pointer MSB compare.
- Reset mid-operation: all buffered bytes are discarded. A request in the reset cycle has no side effect and yields rsp_rdata=0.

Decomposition:
- Shared package mmio_pkg holds the offset constants (OFF_CTRL, OFF_RX, OFF_TX, OFF_CYCLE, OFF_INSTR, OFF_CNTRST) and the CTRL bit indices.
- One natural sub-module is sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty), instantiated for TX and RX. It implements the push-when-full-with-pop acceptance rule internally.

Test Plan:
- Reset, then read 0x8000_0000 -> next-cycle rsp_rdata=0x0000_0001; tx_valid=0.
- With tx_ready=0, write 0x41,0x42 to 0x8000_0008, then raise tx_ready -> tx_data 0x41 then 0x42 on consecutive accepts; tx_valid drops after the second.
- With tx_ready=0, write 9 bytes (TX_DEPTH=8) -> 9th byte dropped; CTRL read=0x0000_0004. Write CTRL with 0x1 -> CTRL read=0x0000_0004 clears to 0x0000_0000.
- Drive rx_valid with 0x5A then 0xA5; read 0x8000_0004 twice -> rsp 0x0000_005A, 0x0000_00A5; a third read -> 0, and CTRL bit1=0.
- Write 0x8000_0018, wait 10 cycles with 3 inst_retire pulses, read 0x8000_0010 and 0x8000_0014 -> cycle count reflecting the exact elapsed cycles; 0x0000_0003.
- Fill RX to 8 entries, then rx_valid in the same cycle as an RX_DATA read -> byte accepted, no rx_overflow. Force cycle_cnt near wrap -> reads 0xFFFF_FFFF then 0x0000_0000.
